// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcode encodings, the
// multiply/divide FSM state type and helpers that classify opcodes.
package exe_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic [5:0] OP_SLL   = 6'h00;
    localparam logic [5:0] OP_SRL   = 6'h02;
    localparam logic [5:0] OP_SRA   = 6'h03;
    localparam logic [5:0] OP_SLLV  = 6'h04;
    localparam logic [5:0] OP_SRLV  = 6'h06;
    localparam logic [5:0] OP_SRAV  = 6'h07;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;
    localparam logic [5:0] OP_ADD   = 6'h20;
    localparam logic [5:0] OP_SUB   = 6'h22;
    localparam logic [5:0] OP_AND   = 6'h24;
    localparam logic [5:0] OP_OR    = 6'h25;
    localparam logic [5:0] OP_XOR   = 6'h26;
    localparam logic [5:0] OP_NOR   = 6'h27;
    localparam logic [5:0] OP_SLT   = 6'h2A;
    localparam logic [5:0] OP_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops that must wait for an in-flight multiply/divide to finish.
    function automatic logic is_hilo_op(input logic [5:0] op);
        return is_muldiv(op) || (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

endpackage

// File: rtl/exe_muldiv.sv
// Multi-cycle multiply/divide unit with HI/LO registers: fixed-latency
// multiply and a one-bit-per-cycle restoring divider on operand magnitudes.
module exe_muldiv
    import exe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MUL_LAT = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [5:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

    md_state_t         state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [DATA_W-1:0] quo_reg, rem_reg;
    logic              signed_reg, neg_q_reg, neg_r_reg, div0_reg;
    logic [DATA_W-1:0] hi_reg, lo_reg;

    logic              op_signed, op_div, a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg     = op_signed && a[DATA_W-1];
    assign b_neg     = op_signed && b[DATA_W-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;

    logic [2*DATA_W-1:0] a_ext, b_ext, prod;

    assign a_ext = signed_reg ? {{DATA_W{a_reg[DATA_W-1]}}, a_reg} : {{DATA_W{1'b0}}, a_reg};
    assign b_ext = signed_reg ? {{DATA_W{b_reg[DATA_W-1]}}, b_reg} : {{DATA_W{1'b0}}, b_reg};
    assign prod  = a_ext * b_ext;

    // quo_reg starts as the dividend and shifts quotient bits in from the right.
    logic [DATA_W:0]   shifted, diff;
    logic              ge;
    logic [DATA_W-1:0] rem_next, quo_next, q_fin, r_fin;

    assign shifted  = {rem_reg, quo_reg[DATA_W-1]};
    assign diff     = shifted - {1'b0, b_reg};
    assign ge       = (shifted >= {1'b0, b_reg});
    assign rem_next = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quo_next = {quo_reg[DATA_W-2:0], ge};
    assign q_fin    = neg_q_reg ? (~quo_next + 1'b1) : quo_next;
    assign r_fin    = neg_r_reg ? (~rem_next + 1'b1) : rem_next;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            signed_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg    <= '0;
                        a_reg      <= a;
                        signed_reg <= op_signed;
                        if (op_div) begin
                            state_reg <= DIV;
                            b_reg     <= b_mag;
                            quo_reg   <= a_mag;
                            rem_reg   <= '0;
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
                            div0_reg  <= (b == '0);
                        end else begin
                            state_reg <= MUL;
                            b_reg     <= b;
                        end
                    end
                end
                MUL: begin
                    if (cnt_reg == MUL_LAST) begin
                        {hi_reg, lo_reg} <= prod;
                        state_reg        <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DIV: begin
                    quo_reg <= quo_next;
                    rem_reg <= rem_next;
                    if (cnt_reg == DIV_LAST) begin
                        state_reg <= IDLE;
                        // Zero divisor still runs the full count, then reports all-ones / dividend.
                        if (div0_reg) begin
                            lo_reg <= '1;
                            hi_reg <= a_reg;
                        end else begin
                            lo_reg <= q_fin;
                            hi_reg <= r_fin;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: rtl/exe_stage_fwd.sv
// Execute stage: MEM/WB operand forwarding, single-cycle ALU, multi-cycle
// multiply/divide unit and the EX/MEM output register with stall/bubble control.
module exe_stage_fwd
    import exe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 3,
    parameter int FWD_EN  = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    input  logic [5:0]        alu_op,
    input  logic [REG_AW-1:0] rs_idx,
    input  logic [REG_AW-1:0] rt_idx,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] imm,
    input  logic              alusrc,
    input  logic [4:0]        shamt,
    input  logic [REG_AW-1:0] wreg,
    input  logic              do_wb,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              memtoreg,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wb_en,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              stall_in,
    output logic              stall_out,
    output logic [DATA_W-1:0] alu_result_pr,
    output logic [DATA_W-1:0] store_data_pr,
    output logic [REG_AW-1:0] wreg_pr,
    output logic              valid_pr,
    output logic              do_wb_pr,
    output logic              memread_pr,
    output logic              memwrite_pr,
    output logic              memtoreg_pr
);

    // Index 0 is rs, index 1 is rt.
    logic [1:0][REG_AW-1:0] src_idx;
    logic [1:0][DATA_W-1:0] src_val;
    logic [1:0][DATA_W-1:0] fwd_val;

    assign src_idx = {rt_idx, rs_idx};
    assign src_val = {rt_val, rs_val};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            if (FWD_EN != 0) begin : g_on
                // MEM is younger than WB, so it wins; r0 is hard-wired and never forwarded.
                assign fwd_val[gi] =
                    (mem_wb_en && (mem_wreg == src_idx[gi]) && (src_idx[gi] != '0)) ? mem_data :
                    (wb_wb_en  && (wb_wreg  == src_idx[gi]) && (src_idx[gi] != '0)) ? wb_data  :
                    src_val[gi];
            end else begin : g_off
                assign fwd_val[gi] = src_val[gi];
            end
        end
    endgenerate

    logic [DATA_W-1:0] op_a, op_b, alu_res, hi, lo;
    logic              md_op, md_start, md_busy;

    assign op_a = fwd_val[0];
    assign op_b = alusrc ? imm : fwd_val[1];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            OP_SLL:  alu_res = op_b << shamt;
            OP_SRL:  alu_res = op_b >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
            OP_SLLV: alu_res = op_b << op_a[4:0];
            OP_SRLV: alu_res = op_b >> op_a[4:0];
            OP_SRAV: alu_res = $unsigned($signed(op_b) >>> op_a[4:0]);
            OP_LUI:  alu_res = imm << 16;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    assign md_op     = is_muldiv(alu_op);
    assign stall_out = in_valid && md_busy && is_hilo_op(alu_op);
    assign md_start  = in_valid && !stall_out && md_op;

    exe_muldiv #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) u_muldiv (
        .CLK   (CLK),
        .RESET (RESET),
        .start (md_start),
        .op    (alu_op),
        .a     (op_a),
        .b     (op_b),
        .busy  (md_busy),
        .hi    (hi),
        .lo    (lo)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            alu_result_pr <= '0;
            store_data_pr <= '0;
            wreg_pr       <= '0;
            valid_pr      <= 1'b0;
            do_wb_pr      <= 1'b0;
            memread_pr    <= 1'b0;
            memwrite_pr   <= 1'b0;
            memtoreg_pr   <= 1'b0;
        end else if (!stall_in) begin
            if (stall_out || !in_valid) begin
                valid_pr    <= 1'b0;
                do_wb_pr    <= 1'b0;
                memread_pr  <= 1'b0;
                memwrite_pr <= 1'b0;
            end else begin
                alu_result_pr <= alu_res;
                store_data_pr <= fwd_val[1];
                wreg_pr       <= wreg;
                valid_pr      <= 1'b1;
                do_wb_pr      <= do_wb && !md_op;
                memread_pr    <= memread;
                memwrite_pr   <= memwrite;
                memtoreg_pr   <= memtoreg;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage_fwd.sv
// Directed bench for exe_stage_fwd: the driver pushes expected EX/MEM contents
// into a scoreboard queue; a negedge monitor pops and compares them.
module tb_exe_stage_fwd;
    import exe_pkg::*;

    localparam int W   = 32;
    localparam int AW  = 5;
    localparam int LAT = 3;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          in_valid = 1'b0;
    logic [5:0]    alu_op = '0;
    logic [AW-1:0] rs_idx = '0, rt_idx = '0, wreg = '0, mem_wreg = '0, wb_wreg = '0;
    logic [W-1:0]  rs_val = '0, rt_val = '0, imm = '0, mem_data = '0, wb_data = '0;
    logic          alusrc = 1'b0;
    logic [4:0]    shamt = '0;
    logic          do_wb = 1'b0, memread = 1'b0, memwrite = 1'b0, memtoreg = 1'b0;
    logic          mem_wb_en = 1'b0, wb_wb_en = 1'b0, stall_in = 1'b0;
    logic          stall_out;
    logic [W-1:0]  alu_result_pr, store_data_pr;
    logic [AW-1:0] wreg_pr;
    logic          valid_pr, do_wb_pr, memread_pr, memwrite_pr, memtoreg_pr;

    always #5 CLK = ~CLK;

    exe_stage_fwd #(.DATA_W(W), .REG_AW(AW), .MUL_LAT(LAT), .FWD_EN(1)) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .alu_op(alu_op),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .alusrc(alusrc), .shamt(shamt), .wreg(wreg),
        .do_wb(do_wb), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .mem_wb_en(mem_wb_en), .mem_wreg(mem_wreg), .mem_data(mem_data),
        .wb_wb_en(wb_wb_en), .wb_wreg(wb_wreg), .wb_data(wb_data),
        .stall_in(stall_in), .stall_out(stall_out),
        .alu_result_pr(alu_result_pr), .store_data_pr(store_data_pr), .wreg_pr(wreg_pr),
        .valid_pr(valid_pr), .do_wb_pr(do_wb_pr), .memread_pr(memread_pr),
        .memwrite_pr(memwrite_pr), .memtoreg_pr(memtoreg_pr)
    );

    typedef struct {
        string         name;
        logic [5:0]    op;
        logic [AW-1:0] rs_idx, rt_idx, wreg, mem_wreg, wb_wreg;
        logic [W-1:0]  rs_val, rt_val, imm, mem_data, wb_data;
        logic          alusrc;
        logic [4:0]    shamt;
        logic          do_wb, mr, mw, mtr, mem_en, wb_en;
        logic [W-1:0]  exp_res, exp_store;
        logic [4:0]    exp_ctrl;   // {valid, do_wb, memread, memwrite, memtoreg}
        logic          chk_res;
        int            exp_stalls;
        int            n_sin;
    } vec_t;

    typedef struct {
        int            due;
        string         name;
        logic [4:0]    ctrl;
        logic [AW-1:0] wreg;
        logic [W-1:0]  res, store;
        logic          chk_res;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    function automatic logic [4:0] ctrl_now();
        return {valid_pr, do_wb_pr, memread_pr, memwrite_pr, memtoreg_pr};
    endfunction

    // Monitor: compare the EX/MEM register on the cycle each entry becomes due.
    always @(negedge CLK) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk({e.name, " ctrl"}, {27'b0, ctrl_now()}, {27'b0, e.ctrl});
            chk({e.name, " wreg"}, {27'b0, wreg_pr}, {27'b0, e.wreg});
            chk({e.name, " store"}, store_data_pr, e.store);
            if (e.chk_res) chk({e.name, " result"}, alu_result_pr, e.res);
            $display("txn %-10s result=%h store=%h wreg=%0d ctrl=%b", e.name,
                     alu_result_pr, store_data_pr, wreg_pr, ctrl_now());
        end
    end

    function automatic vec_t mk(input string name, input logic [5:0] op,
                                input logic [AW-1:0] rsi, input logic [W-1:0] rsv,
                                input logic [AW-1:0] rti, input logic [W-1:0] rtv,
                                input logic [W-1:0] res);
        vec_t v;
        v.name = name;   v.op = op;
        v.rs_idx = rsi;  v.rs_val = rsv;  v.rt_idx = rti;  v.rt_val = rtv;
        v.imm = '0;      v.alusrc = 1'b0; v.shamt = '0;    v.wreg = 5'd3;
        v.do_wb = 1'b1;  v.mr = 1'b0;     v.mw = 1'b0;     v.mtr = 1'b0;
        v.mem_en = 1'b0; v.mem_wreg = '0; v.mem_data = '0;
        v.wb_en = 1'b0;  v.wb_wreg = '0;  v.wb_data = '0;
        v.exp_res = res; v.exp_store = rtv; v.exp_ctrl = 5'b11000;
        v.chk_res = 1'b1; v.exp_stalls = 0; v.n_sin = 0;
        return v;
    endfunction

    // Present one instruction; count stall_out cycles, check bubbles and held
    // outputs, then queue the expected EX/MEM contents for the acceptance edge.
    task automatic issue(input vec_t v);
        int   stalls;
        int   sin;
        bit   bub;
        exp_t e;
        in_valid = 1'b1;  alu_op = v.op;
        rs_idx = v.rs_idx; rs_val = v.rs_val; rt_idx = v.rt_idx; rt_val = v.rt_val;
        imm = v.imm; alusrc = v.alusrc; shamt = v.shamt; wreg = v.wreg;
        do_wb = v.do_wb; memread = v.mr; memwrite = v.mw; memtoreg = v.mtr;
        mem_wb_en = v.mem_en; mem_wreg = v.mem_wreg; mem_data = v.mem_data;
        wb_wb_en = v.wb_en; wb_wreg = v.wb_wreg; wb_data = v.wb_data;
        sin = v.n_sin;
        stall_in = (sin > 0);
        stalls = 0;
        bub = 1'b0;
        forever begin
            @(negedge CLK);
            if (bub) begin
                chk({v.name, " bubble"}, {31'b0, valid_pr}, 32'd0);
                bub = 1'b0;
            end
            if (sin > 0) begin
                chk({v.name, " hold ctrl"}, {27'b0, ctrl_now()}, {27'b0, last_exp.ctrl});
                chk({v.name, " hold result"}, alu_result_pr, last_exp.res);
                chk({v.name, " hold store"}, store_data_pr, last_exp.store);
                @(posedge CLK); #1;
                sin--;
                stall_in = (sin > 0);
            end else if (stall_out) begin
                stalls++;
                bub = 1'b1;
                if (stalls > 100) break;
                @(posedge CLK); #1;
            end else begin
                e.due = cyc + 1;  e.name = v.name;  e.ctrl = v.exp_ctrl;
                e.wreg = v.wreg;  e.res = v.exp_res; e.store = v.exp_store;
                e.chk_res = v.chk_res;
                sb_q.push_back(e);
                last_exp = e;
                @(posedge CLK); #1;
                break;
            end
        end
        chk({v.name, " stall cycles"}, stalls, v.exp_stalls);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        stall_in = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctrl"}, {27'b0, ctrl_now()}, 32'd0);
        chk({tag, " result"}, alu_result_pr, 32'd0);
        chk({tag, " store"}, store_data_pr, 32'd0);
        chk({tag, " wreg"}, {27'b0, wreg_pr}, 32'd0);
    endtask

    initial begin
        vec_t v;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        chk("reset stall_out", {31'b0, stall_out}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;

        // Forwarding priority and r0 exclusion
        v = mk("fwd_mem", OP_ADD, 5'd1, 32'd1, 5'd2, 32'd2, 32'd12);
        v.mem_en = 1'b1; v.mem_wreg = 5'd1; v.mem_data = 32'd10;
        v.wb_en = 1'b1;  v.wb_wreg = 5'd1;  v.wb_data = 32'd20;
        issue(v);
        v = mk("fwd_r0", OP_ADD, 5'd0, 32'd0, 5'd2, 32'd2, 32'd2);
        v.mem_en = 1'b1; v.mem_wreg = 5'd0; v.mem_data = 32'd10;
        v.wb_en = 1'b1;  v.wb_wreg = 5'd0;  v.wb_data = 32'd20;
        issue(v);
        v = mk("fwd_wb", OP_ADD, 5'd1, 32'd1, 5'd2, 32'd2, 32'd21);
        v.wb_en = 1'b1; v.wb_wreg = 5'd2; v.wb_data = 32'd20; v.exp_store = 32'd20;
        issue(v);

        // Single-cycle ALU ops
        issue(mk("sub", OP_SUB, 5'd1, 32'd5, 5'd2, 32'd7, 32'hFFFF_FFFE));
        issue(mk("slt", OP_SLT, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 32'd1));
        issue(mk("sltu", OP_SLTU, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 32'd0));
        v = mk("sra", OP_SRA, 5'd0, 32'd0, 5'd2, 32'h8000_0000, 32'hF800_0000);
        v.shamt = 5'd4;
        issue(v);
        issue(mk("sllv", OP_SLLV, 5'd1, 32'd4, 5'd2, 32'd1, 32'd16));
        v = mk("lui", OP_LUI, 5'd0, 32'd0, 5'd0, 32'd0, 32'h1234_0000);
        v.imm = 32'h1234; v.alusrc = 1'b1;
        issue(v);
        issue(mk("nor", OP_NOR, 5'd1, 32'd0, 5'd2, 32'd0, 32'hFFFF_FFFF));
        v = mk("sw_fwd", OP_ADD, 5'd1, 32'h100, 5'd5, 32'd0, 32'h108);
        v.imm = 32'd8; v.alusrc = 1'b1; v.do_wb = 1'b0; v.mw = 1'b1;
        v.mem_en = 1'b1; v.mem_wreg = 5'd5; v.mem_data = 32'hDEAD_BEEF;
        v.exp_store = 32'hDEAD_BEEF; v.exp_ctrl = 5'b10010;
        issue(v);

        // Signed multiply, then HI/LO reads that must wait out the latency
        v = mk("mult", OP_MULT, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd2, 32'd0);
        v.chk_res = 1'b0; v.exp_ctrl = 5'b10000;
        issue(v);
        v = mk("mfhi_mul", OP_MFHI, 5'd0, 32'd0, 5'd0, 32'd0, 32'hFFFF_FFFF);
        v.exp_stalls = LAT;
        issue(v);
        issue(mk("mflo_mul", OP_MFLO, 5'd0, 32'd0, 5'd0, 32'd0, 32'hFFFF_FFFE));

        // Signed divide -7/2
        v = mk("div", OP_DIV, 5'd1, 32'hFFFF_FFF9, 5'd2, 32'd2, 32'd0);
        v.chk_res = 1'b0; v.exp_ctrl = 5'b10000;
        issue(v);
        v = mk("mflo_div", OP_MFLO, 5'd0, 32'd0, 5'd0, 32'd0, 32'hFFFF_FFFD);
        v.exp_stalls = W;
        issue(v);
        issue(mk("mfhi_div", OP_MFHI, 5'd0, 32'd0, 5'd0, 32'd0, 32'hFFFF_FFFF));

        // Unsigned divide by zero
        v = mk("divu0", OP_DIVU, 5'd1, 32'd5, 5'd2, 32'd0, 32'd0);
        v.chk_res = 1'b0; v.exp_ctrl = 5'b10000;
        issue(v);
        v = mk("mfhi_dz", OP_MFHI, 5'd0, 32'd0, 5'd0, 32'd0, 32'd5);
        v.exp_stalls = W;
        issue(v);
        issue(mk("mflo_dz", OP_MFLO, 5'd0, 32'd0, 5'd0, 32'd0, 32'hFFFF_FFFF));

        // ALU op overlaps a divide; a multiply behind it stalls with bubbles
        v = mk("divu_ov", OP_DIVU, 5'd1, 32'd100, 5'd2, 32'd7, 32'd0);
        v.chk_res = 1'b0; v.exp_ctrl = 5'b10000;
        issue(v);
        issue(mk("add_ov", OP_ADD, 5'd1, 32'd3, 5'd2, 32'd4, 32'd7));
        v = mk("multu_ov", OP_MULTU, 5'd1, 32'h1_0000, 5'd2, 32'h1_0000, 32'd0);
        v.chk_res = 1'b0; v.exp_ctrl = 5'b10000; v.exp_stalls = W - 1;
        issue(v);
        v = mk("mfhi_ov", OP_MFHI, 5'd0, 32'd0, 5'd0, 32'd0, 32'd1);
        v.exp_stalls = LAT;
        issue(v);
        issue(mk("mflo_ov", OP_MFLO, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0));

        // Downstream stall holds EX/MEM while a store waits in EX
        issue(mk("pre_sw", OP_ADD, 5'd1, 32'd3, 5'd2, 32'd4, 32'd7));
        v = mk("sw_held", OP_ADD, 5'd1, 32'h200, 5'd6, 32'd0, 32'h204);
        v.imm = 32'd4; v.alusrc = 1'b1; v.do_wb = 1'b0; v.mw = 1'b1;
        v.mem_en = 1'b1; v.mem_wreg = 5'd6; v.mem_data = 32'hCAFE_F00D;
        v.exp_store = 32'hCAFE_F00D; v.exp_ctrl = 5'b10010; v.n_sin = 3;
        issue(v);

        // Reset in the middle of a divide
        v = mk("divu_rst", OP_DIVU, 5'd1, 32'd100, 5'd2, 32'd7, 32'd0);
        v.chk_res = 1'b0; v.exp_ctrl = 5'b10000;
        issue(v);
        idle(9);
        RESET = 1'b0;
        @(negedge CLK);
        chk_all_zero("mid-div reset");
        @(posedge CLK); #1;
        RESET = 1'b1;
        issue(mk("mfhi_rst", OP_MFHI, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0));
        issue(mk("mflo_rst", OP_MFLO, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0));

        idle(3);
        chk("scoreboard drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
